cbi980_apb: RTL and testbench

CBI980_APB -- requirements
Module: cbi980_apb

---
 rtl/cbi980_apb_if.sv | 23 ++
 rtl/cbi980_apb.sv | 154 +++++++++++++++
 tb/tb_cbi980_apb.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/cbi980_apb_if.sv
// APB4 slave-side bus bundle for the cbi980 core bridge.
// Signal names follow the APB4 specification.
interface cbi980_apb_if;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [4:0]  PADDR;
  logic [31:0] PWDATA;
  logic [3:0]  PSTRB;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/cbi980_apb.sv
// APB4 slave bridge to the cbi980 core register/FIFO port. Issues single-cycle write
// and read-request pulses, waits for the core read echo with a timeout, and responds.
module cbi980_apb #(
  parameter int unsigned RD_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rstn,
  cbi980_apb_if.slave       apb,
  output logic [2:0]        wr_addr,
  output logic [31:0]       wr_data,
  output logic              wr_en,
  input  logic              wr_err,
  output logic [2:0]        rd_addr,
  output logic              rd_valid_in,
  input  logic [31:0]       rd_data,
  input  logic              rd_valid_out
);

  typedef enum logic [2:0] {
    StIdle,
    StWr,
    StWrResp,
    StRdReq,
    StRdWait,
    StResp
  } state_e;

  localparam logic [7:0] TimeoutLast = 8'(RD_TIMEOUT - 1);

  state_e      state_q, state_d;
  logic        pready_q, pready_d;
  logic        pslverr_q, pslverr_d;
  logic [31:0] prdata_q, prdata_d;
  logic        wr_en_q, wr_en_d;
  logic        rd_valid_in_q, rd_valid_in_d;
  logic [2:0]  wr_addr_q, wr_addr_d;
  logic [2:0]  rd_addr_q, rd_addr_d;
  logic [31:0] wr_data_q, wr_data_d;
  logic [7:0]  cnt_q, cnt_d;

  logic setup, bad_req;
  assign setup   = apb.PSEL && !apb.PENABLE;
  assign bad_req = (apb.PADDR[1:0] != 2'b00) || (apb.PWRITE && (apb.PSTRB != 4'hF));

  always_comb begin
    state_d       = state_q;
    pready_d      = 1'b0;
    pslverr_d     = 1'b0;
    prdata_d      = prdata_q;
    wr_en_d       = 1'b0;
    rd_valid_in_d = 1'b0;
    wr_addr_d     = wr_addr_q;
    rd_addr_d     = rd_addr_q;
    wr_data_d     = wr_data_q;
    cnt_d         = cnt_q;

    unique case (state_q)
      StIdle: begin
        if (setup) begin
          if (bad_req) begin
            state_d   = StResp;
            pready_d  = 1'b1;
            pslverr_d = 1'b1;
            prdata_d  = '0;
          end else if (apb.PWRITE) begin
            state_d   = StWr;
            wr_en_d   = 1'b1;
            wr_addr_d = apb.PADDR[4:2];
            wr_data_d = apb.PWDATA;
          end else begin
            state_d       = StRdReq;
            rd_valid_in_d = 1'b1;
            rd_addr_d     = apb.PADDR[4:2];
          end
        end
      end
      StWr: begin
        // Abort leaves the already-issued pulse in place; wr_err is only meaningful here.
        if (!apb.PSEL) begin
          state_d = StIdle;
        end else begin
          state_d   = StWrResp;
          pready_d  = 1'b1;
          pslverr_d = wr_err;
        end
      end
      StRdReq: begin
        if (!apb.PSEL) begin
          state_d = StIdle;
        end else begin
          state_d = StRdWait;
          cnt_d   = '0;
        end
      end
      StRdWait: begin
        if (!apb.PSEL) begin
          state_d = StIdle;
        end else if (rd_valid_out) begin
          state_d  = StResp;
          pready_d = 1'b1;
          prdata_d = rd_data;
        end else if (cnt_q == TimeoutLast) begin
          state_d   = StResp;
          pready_d  = 1'b1;
          pslverr_d = 1'b1;
          prdata_d  = '0;
        end else if (cnt_q != 8'hFF) begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StWrResp, StResp: begin
        // PREADY cycle: a setup seen on this edge is not accepted.
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q       <= StIdle;
      pready_q      <= 1'b0;
      pslverr_q     <= 1'b0;
      prdata_q      <= '0;
      wr_en_q       <= 1'b0;
      rd_valid_in_q <= 1'b0;
      wr_addr_q     <= '0;
      rd_addr_q     <= '0;
      wr_data_q     <= '0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      pready_q      <= pready_d;
      pslverr_q     <= pslverr_d;
      prdata_q      <= prdata_d;
      wr_en_q       <= wr_en_d;
      rd_valid_in_q <= rd_valid_in_d;
      wr_addr_q     <= wr_addr_d;
      rd_addr_q     <= rd_addr_d;
      wr_data_q     <= wr_data_d;
      cnt_q         <= cnt_d;
    end
  end

  assign apb.PREADY  = pready_q;
  assign apb.PSLVERR = pslverr_q;
  assign apb.PRDATA  = prdata_q;
  assign wr_en       = wr_en_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;
  assign rd_valid_in = rd_valid_in_q;
  assign rd_addr     = rd_addr_q;

endmodule

// File: tb/tb_cbi980_apb.sv
// Scoreboard bench for cbi980_apb: APB master tasks, a simple core model, and
// queues of expected responses and core pulses.
module tb_cbi980_apb;
  localparam int unsigned RdTimeout = 15;

  logic        clk;
  logic        rstn;
  logic [2:0]  wr_addr;
  logic [31:0] wr_data;
  logic        wr_en;
  logic        wr_err;
  logic [2:0]  rd_addr;
  logic        rd_valid_in;
  logic [31:0] rd_data;
  logic        rd_valid_out;

  cbi980_apb_if apb ();

  cbi980_apb #(.RD_TIMEOUT(RdTimeout)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .apb          (apb),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .wr_en        (wr_en),
    .wr_err       (wr_err),
    .rd_addr      (rd_addr),
    .rd_valid_in  (rd_valid_in),
    .rd_data      (rd_data),
    .rd_valid_out (rd_valid_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        err;
    logic [31:0] prd;
    logic [7:0]  lat;
  } resp_t;

  typedef struct packed {
    logic [2:0]  addr;
    logic [31:0] data;
  } wr_t;

  resp_t       resp_q[$];
  wr_t         wr_q[$];
  logic [2:0]  rd_q[$];

  int          vectors = 0;
  int          miscompares = 0;
  int          wr_cnt = 0;
  int          rd_cnt = 0;
  int          pready_cnt = 0;
  int          n_done = 0;
  logic        wr_err_mode = 1'b0;
  logic        respond_en = 1'b0;
  logic [31:0] rd_resp_data = '0;
  logic [31:0] exp_prdata = '0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Core model: wr_err driven continuously so it must be ignored outside wr_en cycles.
  assign wr_err = wr_err_mode;
  always @(posedge clk) begin
    rd_valid_out <= rd_valid_in && respond_en;
    rd_data      <= (rd_valid_in && respond_en) ? rd_resp_data : 32'hDEAD_BEEF;
  end

  always @(negedge clk) begin
    if (wr_en) begin
      wr_cnt++;
      check_eq("wr_expected", 64'(wr_q.size() != 0), 64'd1);
      if (wr_q.size() != 0) begin
        wr_t w;
        w = wr_q.pop_front();
        check_eq("wr_addr", 64'(wr_addr), 64'(w.addr));
        check_eq("wr_data", 64'(wr_data), 64'(w.data));
      end
    end
    if (rd_valid_in) begin
      rd_cnt++;
      check_eq("rd_expected", 64'(rd_q.size() != 0), 64'd1);
      if (rd_q.size() != 0) check_eq("rd_addr", 64'(rd_addr), 64'(rd_q.pop_front()));
    end
    if (apb.PREADY) begin
      pready_cnt++;
      check_eq("pready_in_access", 64'(apb.PSEL && apb.PENABLE), 64'd1);
    end
  end

  task automatic apb_tx(input logic wr, input logic [4:0] addr, input logic [31:0] data,
                        input logic [3:0] strb, input logic werr, input logic respond,
                        input logic [31:0] rdat);
    resp_t e, got_e;
    logic  bad;
    int    w0, r0, exp_w, exp_r;
    int    lat;
    bad   = (addr[1:0] != 2'b00) || (wr && strb != 4'hF);
    exp_w = 0;
    exp_r = 0;
    if (bad) begin
      e = '{err: 1'b1, prd: 32'h0, lat: 8'd1};
    end else if (wr) begin
      e = '{err: werr, prd: exp_prdata, lat: 8'd2};
      wr_q.push_back('{addr: addr[4:2], data: data});
      exp_w = 1;
    end else begin
      if (respond) e = '{err: 1'b0, prd: rdat, lat: 8'd3};
      else         e = '{err: 1'b1, prd: 32'h0, lat: 8'(RdTimeout + 2)};
      rd_q.push_back(addr[4:2]);
      exp_r = 1;
    end
    exp_prdata = e.prd;
    resp_q.push_back(e);
    w0 = wr_cnt;
    r0 = rd_cnt;

    @(negedge clk);
    wr_err_mode  = werr;
    respond_en   = respond;
    rd_resp_data = rdat;
    apb.PSEL     = 1'b1;
    apb.PENABLE  = 1'b0;
    apb.PWRITE   = wr;
    apb.PADDR    = addr;
    apb.PWDATA   = data;
    apb.PSTRB    = strb;
    @(negedge clk);
    apb.PENABLE = 1'b1;
    lat = 1;
    while (!apb.PREADY && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    got_e = resp_q.pop_front();
    check_eq("latency", 64'(lat), 64'(got_e.lat));
    check_eq("pslverr", 64'(apb.PSLVERR), 64'(got_e.err));
    check_eq("prdata", 64'(apb.PRDATA), 64'(got_e.prd));
    check_eq("wr_pulses", 64'(wr_cnt - w0), 64'(exp_w));
    check_eq("rd_pulses", 64'(rd_cnt - r0), 64'(exp_r));
    n_done++;
  endtask

  task automatic apb_idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      apb.PSEL    = 1'b0;
      apb.PENABLE = 1'b0;
    end
  endtask

  task automatic check_reset_vals();
    check_eq("rst_pready", 64'(apb.PREADY), 64'd0);
    check_eq("rst_pslverr", 64'(apb.PSLVERR), 64'd0);
    check_eq("rst_prdata", 64'(apb.PRDATA), 64'd0);
    check_eq("rst_wr_en", 64'(wr_en), 64'd0);
    check_eq("rst_rd_valid_in", 64'(rd_valid_in), 64'd0);
    check_eq("rst_wr_addr", 64'(wr_addr), 64'd0);
    check_eq("rst_rd_addr", 64'(rd_addr), 64'd0);
    check_eq("rst_wr_data", 64'(wr_data), 64'd0);
  endtask

  initial begin
    int r0;
    rstn        = 1'b0;
    apb.PSEL    = 1'b0;
    apb.PENABLE = 1'b0;
    apb.PWRITE  = 1'b0;
    apb.PADDR   = '0;
    apb.PWDATA  = '0;
    apb.PSTRB   = '0;
    repeat (3) @(negedge clk);
    check_reset_vals();
    rstn = 1'b1;
    apb_idle(2);

    apb_tx(1'b1, 5'h08, 32'h0000_00F4, 4'hF, 1'b0, 1'b0, 32'h0);
    apb_tx(1'b1, 5'h04, 32'hCAFE_0001, 4'hF, 1'b1, 1'b0, 32'h0);
    apb_tx(1'b0, 5'h18, 32'h0,         4'hF, 1'b1, 1'b1, 32'h1234_5678);
    apb_tx(1'b1, 5'h00, 32'hA5A5_5A5A, 4'hF, 1'b0, 1'b0, 32'h0);
    check_eq("rd_addr_hold", 64'(rd_addr), 64'd6);
    apb_tx(1'b0, 5'h1C, 32'h0,         4'hF, 1'b0, 1'b0, 32'h0);
    apb_tx(1'b0, 5'h0A, 32'h0,         4'hF, 1'b0, 1'b1, 32'h5555_AAAA);
    apb_tx(1'b1, 5'h0A, 32'h1111_2222, 4'hF, 1'b0, 1'b0, 32'h0);
    apb_tx(1'b1, 5'h0C, 32'h3333_4444, 4'h3, 1'b0, 1'b0, 32'h0);
    check_eq("wr_addr_hold", 64'(wr_addr), 64'd0);
    apb_tx(1'b0, 5'h14, 32'h0,         4'h0, 1'b0, 1'b1, 32'h0BAD_F00D);
    apb_idle(1);

    // PSEL dropped while waiting for the core: no PREADY, single pop only.
    rd_q.push_back(3'd3);
    r0 = rd_cnt;
    respond_en  = 1'b0;
    @(negedge clk);
    apb.PSEL    = 1'b1;
    apb.PENABLE = 1'b0;
    apb.PWRITE  = 1'b0;
    apb.PADDR   = 5'h0C;
    @(negedge clk);
    apb.PENABLE = 1'b1;
    repeat (3) @(negedge clk);
    apb_idle(RdTimeout + 4);
    check_eq("abort_rd_pulses", 64'(rd_cnt - r0), 64'd1);
    apb_tx(1'b0, 5'h10, 32'h0, 4'h0, 1'b0, 1'b1, 32'h0F0F_0F0F);

    // Reset during the read-request cycle with the core echo still in flight.
    rd_q.push_back(3'd4);
    respond_en   = 1'b1;
    rd_resp_data = 32'hBAD0_0001;
    @(negedge clk);
    apb.PSEL    = 1'b1;
    apb.PENABLE = 1'b0;
    apb.PWRITE  = 1'b0;
    apb.PADDR   = 5'h10;
    @(negedge clk);
    apb.PENABLE = 1'b1;
    rstn        = 1'b0;
    @(negedge clk);
    check_reset_vals();
    exp_prdata  = '0;
    rstn        = 1'b1;
    apb.PSEL    = 1'b0;
    apb.PENABLE = 1'b0;
    @(negedge clk);
    check_eq("post_rst_pready", 64'(apb.PREADY), 64'd0);
    check_eq("post_rst_prdata", 64'(apb.PRDATA), 64'd0);

    r0 = rd_cnt;
    apb_tx(1'b0, 5'h00, 32'h0, 4'h0, 1'b0, 1'b1, 32'h0000_0001);
    apb_tx(1'b0, 5'h04, 32'h0, 4'h0, 1'b0, 1'b1, 32'h0000_0002);
    apb_tx(1'b0, 5'h08, 32'h0, 4'h0, 1'b0, 1'b1, 32'h0000_0003);
    apb_tx(1'b0, 5'h0C, 32'h0, 4'h0, 1'b0, 1'b1, 32'h0000_0004);
    check_eq("b2b_rd_pulses", 64'(rd_cnt - r0), 64'd4);
    apb_idle(3);

    check_eq("pready_total", 64'(pready_cnt), 64'(n_done));
    check_eq("wr_q_drained", 64'(wr_q.size()), 64'd0);
    check_eq("rd_q_drained", 64'(rd_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
